// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter (8N1, LSB first).
// Ports: clk, rst_n (async low), data/valid/ready push port,
//   uart_tx serial line, busy, fifo_count.
// Define UART_TX_PARITY_EN for an even-parity bit (8E1 frames).
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  data,
  input  logic                        valid,
  output logic                        ready,
  output logic                        uart_tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int TW  = (CPB > 1) ? $clog2(CPB) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;
  logic par_q;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_e;
`endif

  state_e        state_q;
  logic [TW-1:0] tmr_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic push;
  logic pop;
  logic last;

  assign ready = (cnt_q != CW'(FIFO_DEPTH));
  assign push  = valid && ready;
  assign pop   = (state_q == IDLE) && (cnt_q != '0);
  assign last  = (tmr_q == TW'(CPB - 1));

  assign uart_tx    = tx_q;
  assign fifo_count = cnt_q;
  assign busy       = (state_q != IDLE) || (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= data;
  end

  // The line is registered from the current state, so it trails the
  // state by one cycle; every bit still lasts exactly CPB cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_q];
`ifdef UART_TX_PARITY_EN
            par_q   <= ^mem_q[rd_q];
`endif
            tmr_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          tx_q <= 1'b0;
          if (last) begin
            tmr_q   <= '0;
            bit_q   <= '0;
            state_q <= DATA;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        DATA: begin
          tx_q <= shift_q[0];
          if (last) begin
            tmr_q   <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx_q <= par_q;
          if (last) begin
            tmr_q   <= '0;
            state_q <= STOP;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
`endif
        STOP: begin
          tx_q <= 1'b1;
          if (last) begin
            tmr_q   <= '0;
            state_q <= IDLE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scoreboard bench for uart_tx_fifo.
// CPB=4, FIFO_DEPTH=4; a line monitor decodes frames and pops expectations.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 44;
`else
  localparam int FRAME = 40;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  logic       uart_tx;
  logic       busy;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q [$];
  int         falls [$];
  logic       pbits [$];
  logic       mon_en = 1'b0;
  logic       mon_act = 1'b0;

  uart_tx_fifo #(
    .CLK_FREQ  (400),
    .BAUD      (100),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (!ready && n < 500) begin
      step();
      n++;
    end
    if (!ready) begin
      tmo("push_ready");
    end else begin
      data  = b;
      valid = 1'b1;
      exp_q.push_back(b);
      step();
      valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || mon_act) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) tmo("wait_idle");
    repeat (3) @(negedge clk);
    chk("idle_tx", uart_tx, 1);
    chk("idle_busy", busy, 0);
  endtask

  // Line monitor: a bench uart_rx that samples inside each bit cell.
  initial begin : monitor
    logic       prev;
    logic [7:0] rx;
    logic [7:0] e;
    prev = 1'b1;
    rx   = '0;
    e    = '0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && prev && !uart_tx) begin
        mon_act = 1'b1;
        falls.push_back(cyc);
        @(negedge clk);
        chk("start_bit", uart_tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          rx[i] = uart_tx;
        end
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_byte: got %0h want none", rx);
        end else begin
          e = exp_q.pop_front();
          chk("rx_byte", rx, e);
        end
`ifdef UART_TX_PARITY_EN
        repeat (4) @(negedge clk);
        pbits.push_back(uart_tx);
        chk("parity_bit", uart_tx, ^e);
`endif
        repeat (4) @(negedge clk);
        chk("stop_bit", uart_tx, 1);
        mon_act = 1'b0;
      end
      prev = uart_tx;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int nf;
    // 1. Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", uart_tx, 1);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_tx", uart_tx, 1);
    chk("post_rst_count", fifo_count, 0);
    mon_en = 1'b1;
    @(negedge clk);

    // 2. Single byte 0x55: latency and busy timing
    data  = 8'h55;
    valid = 1'b1;
    exp_q.push_back(8'h55);
    step();
    valid = 1'b0;
    chk("lat_e0_count", fifo_count, 1);
    chk("lat_e0_busy", busy, 1);
    chk("lat_e0_tx", uart_tx, 1);
    step();
    chk("lat_e1_tx", uart_tx, 1);
    chk("lat_e1_count", fifo_count, 0);
    step();
    chk("lat_e2_tx", uart_tx, 0);
    repeat (FRAME - 2) step();
    chk("busy_in_stop", busy, 1);
    repeat (2) step();
    chk("busy_after", busy, 0);
    chk("tx_after", uart_tx, 1);
    wait_idle();

    // 3. Fill: 0x01..0x06 back to back; 0x06 meets a full FIFO
    for (int i = 0; i < 6; i++) begin
      data  = 8'(i + 1);
      valid = 1'b1;
      if (i < 5) exp_q.push_back(8'(i + 1));
      step();
      if (i == 0) chk("fill_cnt0", fifo_count, 1);
      if (i == 1) chk("fill_cnt1", fifo_count, 1);
      if (i == 4) begin
        chk("fill_full_cnt", fifo_count, 4);
        chk("fill_full_rdy", ready, 0);
      end
      if (i == 5) chk("fill_drop_cnt", fifo_count, 4);
    end
    valid = 1'b0;
    push_byte(8'h06);
    wait_idle();

    // 4. Back-to-back frames
    nf = falls.size();
    push_byte(8'hA3);
    push_byte(8'h3C);
    wait_idle();
    if (falls.size() >= nf + 2)
      chk("b2b_gap", falls[nf + 1] - falls[nf], FRAME + 1);
    else
      tmo("b2b_frames");

    // 5. Push on the pop cycle
    data  = 8'h11;
    valid = 1'b1;
    exp_q.push_back(8'h11);
    step();
    chk("sim_cnt_a", fifo_count, 1);
    data = 8'h7E;
    exp_q.push_back(8'h7E);
    step();
    valid = 1'b0;
    chk("sim_cnt_b", fifo_count, 1);
    wait_idle();

`ifdef UART_TX_PARITY_EN
    // 6. Parity
    pbits.delete();
    push_byte(8'h07);
    push_byte(8'h03);
    wait_idle();
    if (pbits.size() == 2) begin
      chk("par_07", pbits[0], 1);
      chk("par_03", pbits[1], 0);
    end else begin
      tmo("par_frames");
    end
`endif

    // Reset dropped mid-frame
    mon_en = 1'b0;
    data  = 8'hF0;
    valid = 1'b1;
    step();
    valid = 1'b0;
    nf = 0;
    while (uart_tx && nf < 20) begin
      step();
      nf++;
    end
    if (uart_tx) tmo("mid_start");
    repeat (6) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", uart_tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_ready", ready, 1);
    step();
    rst_n = 1'b1;
    repeat (FRAME) begin
      step();
      if (uart_tx !== 1'b1) begin
        chk("mid_abandon", uart_tx, 1);
        break;
      end
    end
    chk("mid_end_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
